// File: rtl/interrupt_controller.sv
// interrupt_controller: latches edge (optionally level) interrupt events plus an NMI, arbitrates by fixed priority, and drives the CPU's NMI/INT/IntAddrLSBs with an INTACK lock.
//   Optional feature macro: INTC_LEVEL_TRIG_EN adds the lvl_sel input. Where lvl_sel[i]=1,
//   pending[i] follows irq_in[i] directly.
//   Ports: MCLK/reset (sync, active-high); irq_in/irq_en/sw_clr per source; nmi_in; INTACK from the CPU;
//   NMI/INT/IntAddrLSBs to the CPU (registered); pending flags; served_vld/served_id pulse at acknowledge.
module interrupt_controller #(
    parameter int         NUM_SRC = 16,
    parameter logic [5:0] NMI_VEC = 6'd62,
    parameter int         ID_W    = 5
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic [NUM_SRC-1:0] sw_clr,
`ifdef INTC_LEVEL_TRIG_EN
    input  logic [NUM_SRC-1:0] lvl_sel,
`endif
    input  logic               nmi_in,
    input  logic               INTACK,
    output logic               NMI,
    output logic               INT,
    output logic [5:0]         IntAddrLSBs,
    output logic [NUM_SRC-1:0] pending,
    output logic               served_vld,
    output logic [ID_W-1:0]    served_id
);
    typedef enum logic [1:0] {IDLE, LOCK, RECOVER} state_t;
    state_t             state_q;
    logic [NUM_SRC-1:0] hist_q, pending_q, pending_d, masked, ack_clr, lvl;
    logic               nmi_hist_q, nmi_pend_q, nmi_pend_d;
    logic               nmi_q, int_q, vld_q, win_any, ack, has_win;
    logic [ID_W-1:0]    win_id, ack_id, id_q;
    logic [5:0]         win_vec, idle_vec, addr_q, lock_vec_q;
`ifdef INTC_LEVEL_TRIG_EN
    assign lvl = lvl_sel;
`else
    assign lvl = '0;
`endif
    assign masked   = pending_q & irq_en;
    assign ack      = (state_q == IDLE) && INTACK;
    assign has_win  = nmi_pend_q | win_any;
    assign ack_id   = nmi_pend_q ? ID_W'(NUM_SRC) : win_id;
    assign idle_vec = nmi_pend_q ? NMI_VEC : win_any ? win_vec : 6'd0;
    // Descending scan so the lowest enabled pending index is the last (winning) assignment.
    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        win_vec = '0;
        ack_clr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win_any = 1'b1;
                win_id  = ID_W'(i);
                win_vec = NMI_VEC - 6'd1 - 6'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++)
            ack_clr[i] = ack && !nmi_pend_q && win_any && (win_id == ID_W'(i));
    end
    // Set is applied after clear so a coincident edge survives a clear; level bits mirror irq_in.
    assign pending_d  = (lvl & irq_in) | (~lvl & ((pending_q & ~(sw_clr | ack_clr)) | (irq_in & ~hist_q)));
    assign nmi_pend_d = (nmi_pend_q & ~ack) | (nmi_in & ~nmi_hist_q);
    always_ff @(posedge MCLK) begin
        hist_q     <= irq_in;
        nmi_hist_q <= nmi_in;
        if (reset) begin
            pending_q  <= '0;
            nmi_pend_q <= 1'b0;
            state_q    <= IDLE;
            nmi_q      <= 1'b0;
            int_q      <= 1'b0;
            addr_q     <= '0;
            vld_q      <= 1'b0;
            id_q       <= '0;
            lock_vec_q <= '0;
        end else begin
            pending_q  <= pending_d;
            nmi_pend_q <= nmi_pend_d;
            vld_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    addr_q <= idle_vec;
                    if (INTACK) begin
                        state_q    <= LOCK;
                        nmi_q      <= 1'b0;
                        int_q      <= 1'b0;
                        lock_vec_q <= idle_vec;
                        vld_q      <= has_win;
                        if (has_win) id_q <= ack_id;
                    end else begin
                        nmi_q <= nmi_pend_q;
                        int_q <= |masked;
                    end
                end
                LOCK: begin
                    addr_q <= lock_vec_q;
                    if (!INTACK) state_q <= RECOVER;
                end
                RECOVER: begin
                    state_q <= IDLE;
                    nmi_q   <= nmi_pend_q;
                    int_q   <= |masked;
                    addr_q  <= idle_vec;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign NMI         = nmi_q;
    assign INT         = int_q;
    assign IntAddrLSBs = addr_q;
    assign pending     = pending_q;
    assign served_vld  = vld_q;
    assign served_id   = id_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed test-plan scenarios plus random traffic checked against a behavioural model.
module tb_interrupt_controller;
    localparam int N  = 16;
    localparam int IW = 5;
    logic          MCLK = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  irq_in = '0, irq_en = '0, sw_clr = '0;
`ifdef INTC_LEVEL_TRIG_EN
    logic [N-1:0]  lvl_sel = '0;
`endif
    logic          nmi_in = 1'b0, INTACK = 1'b0;
    logic          NMI, INT, served_vld;
    logic [5:0]    IntAddrLSBs;
    logic [N-1:0]  pending;
    logic [IW-1:0] served_id;

    interrupt_controller #(.NUM_SRC(N), .NMI_VEC(6'd62), .ID_W(IW)) dut (
        .MCLK(MCLK), .reset(reset), .irq_in(irq_in), .irq_en(irq_en), .sw_clr(sw_clr),
`ifdef INTC_LEVEL_TRIG_EN
        .lvl_sel(lvl_sel),
`endif
        .nmi_in(nmi_in), .INTACK(INTACK), .NMI(NMI), .INT(INT), .IntAddrLSBs(IntAddrLSBs),
        .pending(pending), .served_vld(served_vld), .served_id(served_id)
    );

    always #5 MCLK = ~MCLK;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending set per source, NMI flag, and a phase (0 idle, 1 locked, 2 recovering).
    bit m_pend[N];
    bit m_prev[N];
    bit m_nmi, m_prevn;
    int m_phase = 0, m_lockvec = 0;
    int e_nmi = 0, e_int = 0, e_addr = 0, e_vld = 0, e_id = 0;

    function automatic bit is_level(int i);
`ifdef INTC_LEVEL_TRIG_EN
        return lvl_sel[i];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        int  w, wvec;
        bit  any_en, acked;
        w = -1;
        any_en = 0;
        for (int i = 0; i < N; i++) if (m_pend[i] && irq_en[i]) any_en = 1;
        if (m_nmi) w = N;
        else for (int i = 0; i < N; i++) if (m_pend[i] && irq_en[i]) begin w = i; break; end
        wvec = (w < 0) ? 0 : (w == N) ? 62 : 62 - 1 - w;
        acked = 0;
        if (reset) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_nmi = 0; m_phase = 0; m_lockvec = 0;
            e_nmi = 0; e_int = 0; e_addr = 0; e_vld = 0; e_id = 0;
        end else begin
            e_vld = 0;
            if (m_phase == 0 && INTACK) begin
                acked = 1;
                e_nmi = 0; e_int = 0; e_addr = wvec; m_lockvec = wvec;
                if (w >= 0) begin e_vld = 1; e_id = w; end
                m_phase = 1;
            end else if (m_phase == 1) begin
                e_addr = m_lockvec;
                if (!INTACK) m_phase = 2;
            end else begin
                e_nmi = m_nmi; e_int = any_en; e_addr = wvec;
                m_phase = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (is_level(i)) m_pend[i] = irq_in[i];
                else begin
                    if (sw_clr[i] || (acked && w == i)) m_pend[i] = 0;
                    if (irq_in[i] && !m_prev[i]) m_pend[i] = 1;
                end
            end
            if (acked && w == N) m_nmi = 0;
            if (nmi_in && !m_prevn) m_nmi = 1;
        end
        for (int i = 0; i < N; i++) m_prev[i] = irq_in[i];
        m_prevn = nmi_in;
    endtask

    task automatic step();
        logic [N-1:0] ep;
        @(posedge MCLK);
        model_edge();
        #1;
        for (int i = 0; i < N; i++) ep[i] = m_pend[i];
        chk("NMI", 32'(NMI), 32'(e_nmi));
        chk("INT", 32'(INT), 32'(e_int));
        chk("addr", 32'(IntAddrLSBs), 32'(e_addr));
        chk("pending", 32'(pending), 32'(ep));
        chk("served_vld", 32'(served_vld), 32'(e_vld));
        chk("served_id", 32'(served_id), 32'(e_id));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Line high through reset produces no event.
        irq_in[3] = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(3);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_int", 32'(INT), 0);
        // Single source served by a two-cycle acknowledge.
        irq_in = '0;
        step();
        irq_en = 16'h0008;
        irq_in[3] = 1'b1;
        step();
        chk("p3_set", 32'(pending[3]), 1);
        step();
        chk("p3_int", 32'(INT), 1);
        chk("p3_vec", 32'(IntAddrLSBs), 58);
        INTACK = 1'b1;
        step();
        chk("p3_vld", 32'(served_vld), 1);
        chk("p3_id", 32'(served_id), 3);
        chk("p3_clr", 32'(pending[3]), 0);
        step();
        chk("p3_vld_once", 32'(served_vld), 0);
        chk("p3_lock_int", 32'(INT), 0);
        INTACK = 1'b0;
        step();
        chk("p3_rec_int", 32'(INT), 0);
        step();
        // NMI beats sources 2 and 5; then 2 before 5.
        irq_in = '0;
        step();
        irq_en = 16'h0024;
        irq_in[5] = 1'b1;
        irq_in[2] = 1'b1;
        nmi_in = 1'b1;
        steps(2);
        chk("nmi_out", 32'(NMI), 1);
        chk("nmi_vec", 32'(IntAddrLSBs), 62);
        INTACK = 1'b1;
        step();
        chk("nmi_id", 32'(served_id), 16);
        INTACK = 1'b0;
        steps(2);
        chk("s2_vec", 32'(IntAddrLSBs), 59);
        INTACK = 1'b1;
        step();
        chk("s2_id", 32'(served_id), 2);
        INTACK = 1'b0;
        steps(2);
        chk("s5_vec", 32'(IntAddrLSBs), 56);
        INTACK = 1'b1;
        step();
        chk("s5_id", 32'(served_id), 5);
        INTACK = 1'b0;
        steps(2);
        // Mask affects INT only; set beats a coincident clear.
        irq_in = '0;
        nmi_in = 1'b0;
        irq_en = '0;
        step();
        irq_in[7] = 1'b1;
        steps(2);
        chk("p7_masked_pend", 32'(pending[7]), 1);
        chk("p7_masked_int", 32'(INT), 0);
        irq_en[7] = 1'b1;
        step();
        chk("p7_en_int", 32'(INT), 1);
        irq_in[7] = 1'b0;
        step();
        irq_in[7] = 1'b1;
        sw_clr[7] = 1'b1;
        step();
        sw_clr = '0;
        chk("p7_set_wins", 32'(pending[7]), 1);
        // Reset in the middle of a lock.
        INTACK = 1'b1;
        steps(2);
        reset = 1'b1;
        step();
        chk("rlock_int", 32'(INT), 0);
        chk("rlock_addr", 32'(IntAddrLSBs), 0);
        chk("rlock_pend", 32'(pending), 0);
        reset = 1'b0;
        INTACK = 1'b0;
        steps(2);
`ifdef INTC_LEVEL_TRIG_EN
        irq_in = '0;
        step();
        lvl_sel[0] = 1'b1;
        irq_en = 16'h0001;
        irq_in[0] = 1'b1;
        steps(2);
        INTACK = 1'b1;
        steps(2);
        INTACK = 1'b0;
        steps(2);
        chk("lvl_hold", 32'(pending[0]), 1);
        chk("lvl_int", 32'(INT), 1);
        irq_in[0] = 1'b0;
        step();
        chk("lvl_drop", 32'(pending[0]), 0);
        lvl_sel = '0;
`endif
        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 19) == 0) irq_en = N'($urandom);
            sw_clr = N'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) nmi_in = ~nmi_in;
`ifdef INTC_LEVEL_TRIG_EN
            if ($urandom_range(0, 99) == 0) lvl_sel = N'($urandom & $urandom);
`endif
            if (INTACK) INTACK = ($urandom_range(0, 1) == 0);
            else INTACK = ($urandom_range(0, 5) == 0);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
